// File: rtl/ddr2_cmd_arbiter.sv
// rtl/ddr2_cmd_arbiter.sv - MIG port-0 command arbiter over a circular DDR2 ring
module ddr2_cmd_arbiter #(
  parameter int          RING_BYTES = 134217728,
  parameter logic [29:0] BASE_ADDR  = 30'd0,
  parameter int          FILL_W     = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calib_done,
  input  logic              clear,
  input  logic [6:0]        burst_len,
  input  logic              wr_req,
  output logic              wr_gnt,
  input  logic              rd_req,
  output logic              rd_gnt,
  input  logic              p0_cmd_full,
  output logic              p0_cmd_en,
  output logic [2:0]        p0_cmd_instr,
  output logic [29:0]       p0_cmd_byte_addr,
  output logic [5:0]        p0_cmd_bl,
  output logic [FILL_W-1:0] fill_words,
  output logic              empty,
  output logic              full
);

  localparam int              PTR_W      = $clog2(RING_BYTES);
  localparam logic [FILL_W:0] RING_WORDS = (FILL_W+1)'(RING_BYTES / 4);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, ptr_step;
  logic [6:0]        bl_act, bl_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              last_rd;
  logic              wr_elig, rd_elig, issue_wr, issue_rd;
  logic              empty_nxt, full_nxt;

  assign wr_elig  = wr_req & calib_done & ~full;
  assign rd_elig  = rd_req & calib_done & ~empty;
  assign ptr_step = PTR_W'({bl_act, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    if (clear) begin
      state_nxt = S_IDLE;
    end else if (state == S_IDLE) begin
      if (!p0_cmd_full && (wr_elig || rd_elig)) begin
        if (wr_elig && rd_elig) begin
          issue_wr = last_rd;
          issue_rd = ~last_rd;
        end else begin
          issue_wr = wr_elig;
          issue_rd = rd_elig;
        end
        state_nxt = S_GAP;
      end
    end else begin
      state_nxt = S_IDLE;
    end
  end

  // Fill settles in the gap cycle, using the grant registered on the issue edge.
  always_comb begin
    fill_nxt = fill_words;
    bl_nxt   = bl_act;
    if (clear) begin
      fill_nxt = '0;
      bl_nxt   = burst_len;
    end else if (wr_gnt) begin
      fill_nxt = fill_words + FILL_W'(bl_act);
    end else if (rd_gnt) begin
      fill_nxt = fill_words - FILL_W'(bl_act);
    end
    empty_nxt = fill_nxt < FILL_W'(bl_nxt);
    full_nxt  = ({1'b0, fill_nxt} + (FILL_W+1)'(bl_nxt)) > RING_WORDS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_gnt           <= 1'b0;
      rd_gnt           <= 1'b0;
      p0_cmd_en        <= 1'b0;
      p0_cmd_instr     <= 3'b000;
      p0_cmd_byte_addr <= BASE_ADDR;
      p0_cmd_bl        <= 6'd63;
      bl_act           <= 7'd64;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fill_words       <= '0;
      empty            <= 1'b1;
      full             <= 1'b0;
      last_rd          <= 1'b1;
    end else begin
      wr_gnt     <= issue_wr;
      rd_gnt     <= issue_rd;
      p0_cmd_en  <= issue_wr | issue_rd;
      fill_words <= fill_nxt;
      bl_act     <= bl_nxt;
      empty      <= empty_nxt;
      full       <= full_nxt;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (issue_wr) begin
        p0_cmd_instr     <= 3'b000;
        p0_cmd_byte_addr <= BASE_ADDR + 30'(wr_ptr);
        p0_cmd_bl        <= 6'(bl_act - 7'd1);
        wr_ptr           <= wr_ptr + ptr_step;
        last_rd          <= 1'b0;
      end else if (issue_rd) begin
        p0_cmd_instr     <= 3'b001;
        p0_cmd_byte_addr <= BASE_ADDR + 30'(rd_ptr);
        p0_cmd_bl        <= 6'(bl_act - 7'd1);
        rd_ptr           <= rd_ptr + ptr_step;
        last_rd          <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ddr2_cmd_arbiter.md
# ddr2_cmd_arbiter

Shares the single MIG port-0 command interface between a write-path requester (input-buffer drain) and a read-path requester (output-buffer fill). Manages the DDR2 region as a circular buffer with its own write and read pointers and a word fill count. Issues a read only over written data and a write only into free space. Sits between the DDR2 read/write sequencing logic and the MIG user port. Round-robin arbitration and one command per two cycles.

## Interface
- RING_BYTES, 134217728: ring size in bytes; power of two, multiple of 256.
- BASE_ADDR, 0: byte address of ring start; 256-byte aligned.
- FILL_W, 26: fill counter width = log2(RING_BYTES/4)+1.
- clk  in  1  system/MIG user clock.
- reset  in  1  asynchronous, active-low reset.
- calib_done  in  1  MIG calibration complete; no grants while low.
- clear  in  1  synchronous; zeroes pointers/fill, latches burst_len.
- burst_len  in  7  words per command, power of two 1..64; sampled only on clear.
- wr_req  in  1  level: one burst of data is already in the MIG write FIFO.
- wr_gnt  out  1  one-cycle pulse: write command issued.
- rd_req  in  1  level: requester can accept one burst.
- rd_gnt  out  1  one-cycle pulse: read command issued.
- p0_cmd_full  in  1  MIG command FIFO full.
- p0_cmd_en  out  1  command strobe.
- p0_cmd_instr  out  3  000 write, 001 read.
- p0_cmd_byte_addr  out  30  command byte address.
- p0_cmd_bl  out  6  active burst length minus 1.
- fill_words  out  FILL_W  words written but not yet read-commanded.
- empty  out  1  fill_words < active burst length.
- full  out  1  fill_words + active burst length > RING_BYTES/4.

## Operation
- Reset values: all strobes/grants 0, p0_cmd_instr 000, p0_cmd_byte_addr BASE_ADDR, p0_cmd_bl 63, active bl 64, pointers 0, fill 0, empty 1, full 0, last-grant = read, state S_IDLE.
- The write pointer and read pointer are byte offsets in [0, RING_BYTES). The address is BASE_ADDR + pointer. The pointer advances by 4*bl modulo RING_BYTES. Because bl is a power of two and RING_BYTES is a multiple of 256, no burst crosses the ring end.
- Eligibility:
  - A write is eligible when wr_req & calib_done & !full.
  - A read is eligible when rd_req & calib_done & !empty.
- States:
  - S_IDLE: if p0_cmd_full is low and any request is eligible, pick the winner. If both are eligible, the winner is the opposite of last-grant. Assert p0_cmd_en, the matching grant, instr, address and bl for exactly one cycle. Update the pointer and fill. Go to S_GAP.
  - S_GAP: one dead cycle so that p0_cmd_full reflects the new command. Return to S_IDLE.
- Fill update: +bl on a write grant, −bl on a read grant. Both never occur in the same cycle. empty and full are registered from the updated fill.
- clear: takes priority over a grant in the same cycle. It zeroes pointers and fill, latches burst_len into the active bl, returns to S_IDLE, and suppresses that cycle's command.
- Requesters drop their req on the cycle after gnt, or keep it high for a following burst. A held req with no grant is legal (stall).
- Async reset asserted mid-command kills the strobe immediately. Outputs take their reset values.

## Timing
- Request to grant: 1 cycle when the request is registered eligible in S_IDLE. Command fields are registered and valid in the same cycle as p0_cmd_en.
- Maximum throughput: one command every 2 cycles. With both requesters busy, they alternate W,R,W,R.
- p0_cmd_full high in S_IDLE: stay in S_IDLE. No grant, no pointer change.
- calib_done low: no grants. Pointers are held.
- fill_words/empty/full update on the cycle after the grant.

## Test plan
- Bench uses RING_BYTES=1024, BASE_ADDR=0x100, and clear with burst_len=16.
- Reset then clear: rd_req high, wr_req low -> no rd_gnt, empty=1. Then one wr_req -> p0_cmd_en with instr 000, address 0x100, bl 15; fill_words=16 next cycle.
- Both requests held continuously after 2 writes -> grants alternate R,W,R,… at 1 per 2 cycles. Read addresses are 0x100, 0x140, …
- Write-only until capacity: 16 write grants take fill to 256 and set full=1. The 17th wr_req stalls. The 16th address is 0x4C0, and the next write after a read wraps to 0x100.
- p0_cmd_full held high 5 cycles with wr_req high -> no p0_cmd_en during the hold. The grant comes 1 cycle after release.
- clear with burst_len=64 in the same cycle as an eligible request -> no command. Fill=0, next p0_cmd_bl=63, write address 0x100.
- Async reset asserted during S_GAP and released -> all outputs at reset values, and calib_done low blocks grants.
